// File: rtl/dmem_lsu_pkg.sv
// Shared encodings, FSM states and request bundle for the data-memory LSU.
// Also holds the lane write-enable helper used by the formatter.
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [3:0] lane_we(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [3:0] we;
        we = 4'b0000;
        case (size)
            SZ_BYTE: we = 4'b0001 << a;
            SZ_HALF: we = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/dmem_lsu_fmt.sv
// Store lane replication, load extract/extend and access legality check.
// Purely combinational; fed by the latched request.
module dmem_lsu_fmt
    import dmem_lsu_pkg::*;
#(
    parameter int DMEM_AW     = 10,
    parameter bit RANGE_CHECK = 1'b1
) (
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rraw_i,
    output logic [3:0]  we_o,
    output logic [31:0] indata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam logic [32:0] LIMIT = 33'd4 << DMEM_AW;

    logic        mis;
    logic        oor;
    logic [7:0]  b;
    logic [15:0] h;

    assign we_o = lane_we(size_i, addr_i[1:0]);
    assign oor  = RANGE_CHECK && ({1'b0, addr_i} >= LIMIT);
    assign err_o = mis | oor;

    always_comb begin
        mis = 1'b0;
        case (size_i)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_i[0];
            SZ_WORD: mis = |addr_i[1:0];
            default: mis = 1'b1;
        endcase
    end

    always_comb begin
        indata_o = wdata_i;
        case (size_i)
            SZ_BYTE: indata_o = {4{wdata_i[7:0]}};
            SZ_HALF: indata_o = {2{wdata_i[15:0]}};
            default: indata_o = wdata_i;
        endcase
    end

    always_comb begin
        b = rraw_i[7:0];
        case (addr_i[1:0])
            2'd0: b = rraw_i[7:0];
            2'd1: b = rraw_i[15:8];
            2'd2: b = rraw_i[23:16];
            2'd3: b = rraw_i[31:24];
            default: b = rraw_i[7:0];
        endcase
    end

    assign h = addr_i[1] ? rraw_i[31:16] : rraw_i[15:0];

    always_comb begin
        rdata_o = rraw_i;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{~uns_i & b[7]}}, b};
            SZ_HALF: rdata_o = {{16{~uns_i & h[15]}}, h};
            default: rdata_o = rraw_i;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_arb.sv
// Two-master round-robin load/store controller for the byte-laned data memory.
// IDLE -> ACCESS -> RESP, one access in flight, response pulse one cycle later.
module dmem_lsu_arb
    import dmem_lsu_pkg::*;
#(
    parameter int DMEM_AW     = 10,
    parameter bit RANGE_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic        m0_uns,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic        m1_uns,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_daddr,
    output logic [31:0] dmem_indata,
    input  logic [31:0] dmem_outdata
);

    state_e      state_q;
    req_t        req_q;
    req_t        req_d;
    logic        owner_q;
    logic        last_q;
    logic [1:0]  rvalid_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        idle;
    logic [3:0]  we_l;
    logic [31:0] ind_l;
    logic [31:0] rfmt;
    logic        err_l;

    // gnt is combinational, so it is masked while reset is held
    assign idle   = (state_q == ST_IDLE) & rst_n;
    assign m0_gnt = idle & m0_req & (~m1_req | last_q);
    assign m1_gnt = idle & m1_req & (~m0_req | ~last_q);

    always_comb begin
        req_d = '{we: m0_we, size: m0_size, uns: m0_uns,
                  addr: m0_addr, wdata: m0_wdata};
        if (m1_gnt) begin
            req_d = '{we: m1_we, size: m1_size, uns: m1_uns,
                      addr: m1_addr, wdata: m1_wdata};
        end
    end

    dmem_lsu_fmt #(
        .DMEM_AW    (DMEM_AW),
        .RANGE_CHECK(RANGE_CHECK)
    ) u_fmt (
        .size_i  (req_q.size),
        .uns_i   (req_q.uns),
        .addr_i  (req_q.addr),
        .wdata_i (req_q.wdata),
        .rraw_i  (dmem_outdata),
        .we_o    (we_l),
        .indata_o(ind_l),
        .rdata_o (rfmt),
        .err_o   (err_l)
    );

    assign dmem_we     = (state_q == ST_ACCESS && req_q.we && !err_l)
                         ? we_l : 4'b0000;
    assign dmem_daddr  = {req_q.addr[31:2], 2'b00};
    assign dmem_indata = ind_l;

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rvalid_q[0] ? rdata_q : 32'h0;
    assign m1_rdata  = rvalid_q[1] ? rdata_q : 32'h0;
    assign m0_err    = rvalid_q[0] & err_q;
    assign m1_err    = rvalid_q[1] & err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            rvalid_q <= 2'b00;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 2'b00;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (m0_gnt | m1_gnt) begin
                        req_q   <= req_d;
                        owner_q <= m1_gnt;
                        last_q  <= m1_gnt;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: state_q <= ST_RESP;
                ST_RESP: begin
                    state_q  <= ST_IDLE;
                    rvalid_q <= owner_q ? 2'b10 : 2'b01;
                    err_q    <= err_l;
                    rdata_q  <= (req_q.we | err_l) ? 32'h0 : rfmt;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_arb.sv
// Directed bench for dmem_lsu_arb with a behavioural byte-laned memory.
// Table of single accesses plus reset-in-flight and arbitration sequences.
module tb_dmem_lsu_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_uns = 0;
    logic [1:0]  m0_size = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 0, m1_we = 0, m1_uns = 0;
    logic [1:0]  m1_size = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_daddr, dmem_indata;
    logic [31:0] dmem_outdata = 32'h0;

    logic [31:0] mem [1024] = '{default: 32'h0};

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_lsu_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size),
        .m0_uns(m0_uns), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size),
        .m1_uns(m1_uns), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .dmem_we(dmem_we), .dmem_daddr(dmem_daddr),
        .dmem_indata(dmem_indata), .dmem_outdata(dmem_outdata)
    );

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (dmem_we[k])
                mem[dmem_daddr[11:2]][8*k +: 8] <= dmem_indata[8*k +: 8];
        dmem_outdata <= mem[dmem_daddr[11:2]];
    end

    typedef struct {
        logic        m;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  ewe;
        logic [31:0] eind;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tv [20];

    function automatic vec_t mk(
        input logic m, input logic we, input logic [1:0] sz,
        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
        input logic [3:0] ewe, input logic [31:0] eind,
        input logic [31:0] erd, input logic eerr
    );
        vec_t v;
        v.m = m; v.we = we; v.sz = sz; v.uns = uns; v.addr = addr;
        v.wd = wd; v.ewe = ewe; v.eind = eind; v.erd = erd; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic r);
        if (v.m) begin
            m1_req = r; m1_we = v.we; m1_size = v.sz; m1_uns = v.uns;
            m1_addr = v.addr; m1_wdata = v.wd;
        end else begin
            m0_req = r; m0_we = v.we; m0_size = v.sz; m0_uns = v.uns;
            m0_addr = v.addr; m0_wdata = v.wd;
        end
    endtask

    task automatic access(input vec_t v, input string tag);
        logic [1:0]  own;
        logic [31:0] rd;
        logic        er;
        own = v.m ? 2'b10 : 2'b01;
        drive(v, 1'b1);
        #1;
        chk({tag, " gnt"}, 32'({m1_gnt, m0_gnt}), 32'(own));
        tick();
        drive(v, 1'b0);
        chk({tag, " we_c1"}, 32'(dmem_we), 32'(v.ewe));
        chk({tag, " daddr"}, dmem_daddr, {v.addr[31:2], 2'b00});
        if (v.ewe != 4'b0000)
            chk({tag, " indata"}, dmem_indata, v.eind);
        chk({tag, " rv_c1"}, 32'({m1_rvalid, m0_rvalid}), 32'h0);
        tick();
        chk({tag, " we_c2"}, 32'(dmem_we), 32'h0);
        chk({tag, " rv_c2"}, 32'({m1_rvalid, m0_rvalid}), 32'h0);
        tick();
        rd = v.m ? m1_rdata : m0_rdata;
        er = v.m ? m1_err : m0_err;
        chk({tag, " rv_c3"}, 32'({m1_rvalid, m0_rvalid}), 32'(own));
        chk({tag, " rdata"}, rd, v.erd);
        chk({tag, " err"}, 32'(er), 32'(v.eerr));
        chk({tag, " we_c3"}, 32'(dmem_we), 32'h0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ctl0"}, 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
                                  m0_err, m1_err, dmem_we}), 32'h0);
        chk({tag, " rd0"}, m0_rdata | m1_rdata, 32'h0);
        chk({tag, " daddr0"}, dmem_daddr, 32'h0);
        chk({tag, " ind0"}, dmem_indata, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        m0_req = 1'b0;
        m1_req = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic w;
        tv[0]  = mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        tv[1]  = mk(0, 0, 2'b10, 0, 32'h10, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 0);
        tv[2]  = mk(0, 1, 2'b00, 0, 32'h13, 32'h123456A5, 4'h8, 32'hA5A5A5A5, 32'h0, 0);
        tv[3]  = mk(0, 0, 2'b00, 0, 32'h13, 32'h0, 4'h0, 32'h0, 32'hFFFFFFA5, 0);
        tv[4]  = mk(0, 0, 2'b00, 1, 32'h13, 32'h0, 4'h0, 32'h0, 32'h000000A5, 0);
        tv[5]  = mk(0, 0, 2'b10, 1, 32'h10, 32'h0, 4'h0, 32'h0, 32'hA5ADBEEF, 0);
        tv[6]  = mk(0, 0, 2'b00, 0, 32'h11, 32'h0, 4'h0, 32'h0, 32'hFFFFFFBE, 0);
        tv[7]  = mk(0, 0, 2'b01, 0, 32'h11, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        tv[8]  = mk(0, 0, 2'b10, 0, 32'h12, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        tv[9]  = mk(0, 0, 2'b10, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        tv[10] = mk(0, 1, 2'b10, 0, 32'h1000, 32'h77777777, 4'h0, 32'h0, 32'h0, 1);
        tv[11] = mk(1, 1, 2'b01, 0, 32'h16, 32'h00001234, 4'hC, 32'h12341234, 32'h0, 0);
        tv[12] = mk(1, 1, 2'b01, 0, 32'h14, 32'hFFFF8001, 4'h3, 32'h80018001, 32'h0, 0);
        tv[13] = mk(1, 0, 2'b01, 0, 32'h14, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 0);
        tv[14] = mk(1, 0, 2'b01, 1, 32'h14, 32'h0, 4'h0, 32'h0, 32'h00008001, 0);
        tv[15] = mk(1, 0, 2'b10, 0, 32'h14, 32'h0, 4'h0, 32'h0, 32'h12348001, 0);
        tv[16] = mk(1, 1, 2'b11, 0, 32'h18, 32'hCAFEF00D, 4'h0, 32'h0, 32'h0, 1);
        tv[17] = mk(1, 0, 2'b01, 0, 32'h16, 32'h0, 4'h0, 32'h0, 32'h00001234, 0);
        tv[18] = mk(0, 1, 2'b01, 0, 32'h11, 32'h0000FFFF, 4'h0, 32'h0, 32'h0, 1);
        tv[19] = mk(0, 0, 2'b10, 0, 32'hFFC, 32'h0, 4'h0, 32'h0, 32'h0, 0);

        do_reset();
        for (int i = 0; i < 20; i++)
            access(tv[i], $sformatf("v%0d", i));

        chk("mem18 untouched", mem[6], 32'h0);
        chk("mem400 untouched", mem[0], 32'h0);

        v = mk(0, 1, 2'b10, 0, 32'h10, 32'h11111111, 4'hF, 32'h11111111, 32'h0, 0);
        drive(v, 1'b1);
        #1;
        chk("rstacc gnt", 32'(m0_gnt), 32'h1);
        tick();
        drive(v, 1'b0);
        chk("rstacc we_c1", 32'(dmem_we), 32'hF);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("rstacc");
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rstacc rv%0d", c),
                32'({m1_rvalid, m0_rvalid, |dmem_we}), 32'h0);
            tick();
        end
        access(mk(0, 0, 2'b10, 0, 32'h10, 32'h0, 4'h0, 32'h0, 32'hA5ADBEEF, 0),
               "rstacc reload");

        do_reset();
        m0_we = 0; m0_size = 2'b10; m0_uns = 0; m0_addr = 32'h10;
        m1_we = 0; m1_size = 2'b10; m1_uns = 0; m1_addr = 32'h14;
        m0_req = 1'b1;
        m1_req = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            w = (i % 2) == 1;
            chk($sformatf("arb%0d gnt", i), 32'({m1_gnt, m0_gnt}),
                w ? 32'h2 : 32'h1);
            tick();
            chk($sformatf("arb%0d busy", i), 32'({m1_gnt, m0_gnt}), 32'h0);
            tick();
            tick();
            chk($sformatf("arb%0d rv", i), 32'({m1_rvalid, m0_rvalid}),
                w ? 32'h2 : 32'h1);
            chk($sformatf("arb%0d rdata", i), w ? m1_rdata : m0_rdata,
                w ? 32'h12348001 : 32'hA5ADBEEF);
            #1;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        chk("arb idle", 32'({m1_rvalid, m0_rvalid, |dmem_we}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
